// File: rtl/drawbridge_sequencer.sv
// Drawbridge sequencer: warn, clear, raise, hold open for boats, lower; sticky fault on bad limit switches.
// Optional motion timeout enabled by defining DBS_TIMEOUT_EN.
module drawbridge_sequencer #(
  parameter int WARN_CYCLES  = 8,
  parameter int MOVE_TIMEOUT = 32,
  parameter int HOLD_MIN     = 4,
  parameter int CNT_W        = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_boatReq,
  input  logic       i_roadClear,
  input  logic       i_bridgeUp,
  input  logic       i_bridgeDown,
  output logic       o_mtUp,
  output logic       o_mtDn,
  output logic       o_al,
  output logic       o_tfl,
  output logic       o_boatGo,
  output logic       o_fault,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WARN       = 3'd1,
    S_CLEAR_WAIT = 3'd2,
    S_RAISE      = 3'd3,
    S_OPEN       = 3'd4,
    S_LOWER      = 3'd5,
    S_FAULT      = 3'd6,
    S_ILLEGAL    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] WARN_LAST = CNT_W'(WARN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MIN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  state_t           w_next;
  logic             w_moveExpired;
  logic             w_mtUp, w_mtDn, w_al, w_tfl, w_boatGo, w_fault;

`ifdef DBS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);
  assign w_moveExpired = (r_timer == MOVE_LAST);
`else
  // Motion waits forever on the limit switch; MOVE_TIMEOUT is only referenced here.
  logic w_unusedMoveTimeout;
  assign w_unusedMoveTimeout = (MOVE_TIMEOUT > 0);
  assign w_moveExpired       = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    if (i_bridgeUp && i_bridgeDown && (r_state != S_FAULT)) begin
      w_next = S_FAULT;
    end else begin
      case (r_state)
        S_IDLE:       if (i_boatReq) w_next = S_WARN;
        S_WARN:       if (r_timer == WARN_LAST) w_next = S_CLEAR_WAIT;
        S_CLEAR_WAIT: if (i_roadClear) w_next = S_RAISE;
        S_RAISE: begin
          if (i_bridgeUp)         w_next = S_OPEN;
          else if (w_moveExpired) w_next = S_FAULT;
        end
        S_OPEN:       if ((r_timer >= HOLD_LAST) && !i_boatReq) w_next = S_LOWER;
        // A returning boat re-opens the bridge even if the deck has just touched down.
        S_LOWER: begin
          if (i_boatReq)          w_next = S_RAISE;
          else if (i_bridgeDown)  w_next = S_IDLE;
          else if (w_moveExpired) w_next = S_FAULT;
        end
        S_FAULT:      w_next = S_FAULT;
        default:      w_next = S_FAULT;
      endcase
    end
  end

  always_comb begin
    w_mtUp   = 1'b0;
    w_mtDn   = 1'b0;
    w_al     = 1'b0;
    w_tfl    = 1'b0;
    w_boatGo = 1'b0;
    w_fault  = 1'b0;
    case (w_next)
      S_IDLE: ;
      S_WARN, S_CLEAR_WAIT: begin
        w_al  = 1'b1;
        w_tfl = 1'b1;
      end
      S_RAISE: begin
        w_mtUp = 1'b1;
        w_al   = 1'b1;
        w_tfl  = 1'b1;
      end
      S_OPEN: begin
        w_tfl    = 1'b1;
        w_boatGo = 1'b1;
      end
      S_LOWER: begin
        w_mtDn = 1'b1;
        w_al   = 1'b1;
        w_tfl  = 1'b1;
      end
      default: begin
        w_al    = 1'b1;
        w_tfl   = 1'b1;
        w_fault = 1'b1;
      end
    endcase
  end

  // Outputs are loaded with the decode of the state being entered, so they track r_state exactly.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      o_mtUp   <= 1'b0;
      o_mtDn   <= 1'b0;
      o_al     <= 1'b0;
      o_tfl    <= 1'b0;
      o_boatGo <= 1'b0;
      o_fault  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)  r_timer <= '0;
      else if (r_timer != '1) r_timer <= r_timer + 1'b1;
      o_mtUp   <= w_mtUp;
      o_mtDn   <= w_mtDn;
      o_al     <= w_al;
      o_tfl    <= w_tfl;
      o_boatGo <= w_boatGo;
      o_fault  <= w_fault;
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_drawbridge_sequencer.sv
// Directed bench for drawbridge_sequencer; expected output vectors are hand-written per state.
module tb_drawbridge_sequencer;

  logic clock = 1'b0;
  logic reset, boatReq, roadClear, bridgeUp, bridgeDown;
  logic mtUp, mtDn, al, tfl, boatGo, fault;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  // Vector layout: {state[2:0], mtUp, mtDn, al, tfl, boatGo, fault}
  localparam logic [8:0] EXP_IDLE  = 9'b000_0_0_0_0_0_0;
  localparam logic [8:0] EXP_WARN  = 9'b001_0_0_1_1_0_0;
  localparam logic [8:0] EXP_CLEAR = 9'b010_0_0_1_1_0_0;
  localparam logic [8:0] EXP_RAISE = 9'b011_1_0_1_1_0_0;
  localparam logic [8:0] EXP_OPEN  = 9'b100_0_0_0_1_1_0;
  localparam logic [8:0] EXP_LOWER = 9'b101_0_1_1_1_0_0;
  localparam logic [8:0] EXP_FAULT = 9'b110_0_0_1_1_0_1;

  wire [8:0] observed = {state, mtUp, mtDn, al, tfl, boatGo, fault};

  always #5 clock = ~clock;

  drawbridge_sequencer dut (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_boatReq   (boatReq),
    .i_roadClear (roadClear),
    .i_bridgeUp  (bridgeUp),
    .i_bridgeDown(bridgeDown),
    .o_mtUp      (mtUp),
    .o_mtDn      (mtDn),
    .o_al        (al),
    .o_tfl       (tfl),
    .o_boatGo    (boatGo),
    .o_fault     (fault),
    .o_state     (state)
  );

  // Advance the given number of rising edges, settling 1 time unit past each one.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    reset      = 1'b1;
    boatReq    = 1'b0;
    roadClear  = 1'b0;
    bridgeUp   = 1'b0;
    bridgeDown = 1'b1;
    applyStimulus(2);
    reset = 1'b0;
  endtask

  // From IDLE: one edge into WARN, eight WARN cycles, one CLEAR_WAIT cycle, then RAISE.
  task automatic runToRaise();
    boatReq   = 1'b1;
    roadClear = 1'b1;
    applyStimulus(10);
    bridgeDown = 1'b0;
  endtask

  initial begin
    // Reset and idle.
    resetDut();
    checkOutput("reset", EXP_IDLE);
    applyStimulus(1);
    checkOutput("idle", EXP_IDLE);

    // Full raise/open/lower cycle with default parameters.
    boatReq   = 1'b1;
    roadClear = 1'b1;
    applyStimulus(1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("warn", EXP_WARN);
      applyStimulus(1);
    end
    checkOutput("clearWaitOneCycle", EXP_CLEAR);
    applyStimulus(1);
    checkOutput("raiseEntry", EXP_RAISE);
    bridgeDown = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("raiseHold", EXP_RAISE);
    end
    bridgeUp = 1'b1;
    applyStimulus(1);
    checkOutput("open0", EXP_OPEN);
    applyStimulus(1);
    checkOutput("open1", EXP_OPEN);
    boatReq = 1'b0;
    applyStimulus(1);
    checkOutput("open2", EXP_OPEN);
    applyStimulus(1);
    checkOutput("open3", EXP_OPEN);
    applyStimulus(1);
    checkOutput("lowerEntry", EXP_LOWER);
    bridgeUp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput("lowerHold", EXP_LOWER);
    end
    bridgeDown = 1'b1;
    applyStimulus(1);
    checkOutput("backToIdle", EXP_IDLE);

    // Deck never clears: CLEAR_WAIT holds indefinitely.
    resetDut();
    boatReq   = 1'b1;
    roadClear = 1'b0;
    applyStimulus(9);
    checkOutput("clearWaitEntry", EXP_CLEAR);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      checkOutput("clearWaitHold", EXP_CLEAR);
    end

    // Top limit switch never arrives.
    resetDut();
    runToRaise();
    checkOutput("stuckRaiseEntry", EXP_RAISE);
`ifdef DBS_TIMEOUT_EN
    for (int i = 0; i < 31; i++) begin
      applyStimulus(1);
      checkOutput("stuckRaiseDriving", EXP_RAISE);
    end
    applyStimulus(1);
    checkOutput("raiseTimeoutFault", EXP_FAULT);
    applyStimulus(5);
    checkOutput("timeoutFaultSticky", EXP_FAULT);
`else
    applyStimulus(100);
    checkOutput("raiseNoTimeout", EXP_RAISE);
`endif

    // Boat returns while lowering.
    resetDut();
    runToRaise();
    bridgeUp = 1'b1;
    applyStimulus(1);
    checkOutput("reopenOpen", EXP_OPEN);
    boatReq = 1'b0;
    applyStimulus(4);
    checkOutput("reopenLower", EXP_LOWER);
    bridgeUp = 1'b0;
    applyStimulus(2);
    checkOutput("reopenLower3", EXP_LOWER);
    boatReq = 1'b1;
    applyStimulus(1);
    checkOutput("reopenRaise", EXP_RAISE);
    bridgeUp = 1'b1;
    applyStimulus(1);
    checkOutput("reopenOpenAgain", EXP_OPEN);

    // Contradictory limit switches while idle.
    resetDut();
    bridgeUp   = 1'b1;
    bridgeDown = 1'b1;
    applyStimulus(1);
    checkOutput("switchFault", EXP_FAULT);
    applyStimulus(3);
    checkOutput("switchFaultSticky", EXP_FAULT);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("faultCleared", EXP_IDLE);
    reset    = 1'b0;
    bridgeUp = 1'b0;
    applyStimulus(1);
    checkOutput("idleAfterFault", EXP_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/drawbridge_sequencer.md
Name: drawbridge_sequencer

Overview:
Moore FSM that sequences one drawbridge through road warning, deck clearing, raising, boat passage and lowering. It drives the bridge motor (up and down), the alarm, the road traffic light and the boat "go" signal. It consumes boat-request, deck-occupancy and limit-switch sensors. Sits above the sensor-decode logic as the single owner of motor and signalling outputs.

Parameters:
WARN_CYCLES, 8, cycles of alarm plus red light before deck-clear check (>=1)
MOVE_TIMEOUT, 32, max cycles allowed in RAISE or LOWER before fault (>=1)
HOLD_MIN, 4, min cycles bridge stays OPEN (>=1)
CNT_W, 16, state-timer width; all cycle parameters must be < 2^CNT_W

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high
BoatReq  in  1  boat present/waiting; held high while a boat needs passage
RoadClear  in  1  1 = no vehicle on deck
BridgeUp  in  1  top limit switch
BridgeDown  in  1  bottom limit switch
MT_UP  out  1  motor raise
MT_DN  out  1  motor lower
AL  out  1  alarm
TFL  out  1  road light: 1 = red, 0 = green
BoatGo  out  1  boat signal green
Fault  out  1  sticky fault indicator
State  out  3  current state code (debug)

Behaviour:
- State codes: IDLE=0, WARN=1, CLEAR_WAIT=2, RAISE=3, OPEN=4, LOWER=5, FAULT=6. Code 7 is unreachable; if it occurs, go to FAULT.
- All outputs are registered and loaded on the same edge as the state register with the decode of the new state. Inputs sampled at edge N produce new state and outputs after edge N (1-cycle latency).
- Reset (any state, including mid-RAISE/LOWER):
  - State=IDLE, timer=0.
  - MT_UP=MT_DN=AL=TFL=BoatGo=Fault=0 after that edge.
- Timer: clears on every state change; otherwise increments each cycle, saturating at all-ones.
- Output decode per state:
  - IDLE: all 0.
  - WARN, CLEAR_WAIT: AL=1, TFL=1.
  - RAISE: MT_UP=1, AL=1, TFL=1.
  - OPEN: TFL=1, BoatGo=1.
  - LOWER: MT_DN=1, AL=1, TFL=1.
  - FAULT: AL=1, TFL=1, Fault=1; motors off.
- Transitions, in priority order:
  - Reset.
  - BridgeUp&BridgeDown=1 in any non-FAULT state -> FAULT.
  - IDLE: BoatReq=1 -> WARN.
  - WARN: timer==WARN_CYCLES-1 -> CLEAR_WAIT. WARN lasts exactly WARN_CYCLES cycles. BoatReq dropping does not abort.
  - CLEAR_WAIT: RoadClear=1 -> RAISE. Waits indefinitely otherwise.
  - RAISE: BridgeUp=1 -> OPEN. Timeout rule applies.
  - OPEN: timer>=HOLD_MIN-1 and BoatReq=0 -> LOWER.
  - LOWER: BoatReq=1 -> RAISE (re-open takes priority over BridgeDown). Else BridgeDown=1 -> IDLE. Timeout rule applies.
  - FAULT: exits only via Reset.
- If BridgeUp is already 1 on entering RAISE, OPEN follows on the next edge. Same for BridgeDown in LOWER.
- Invariants:
  - MT_UP&MT_DN never both 1.
  - BoatGo=1 only in OPEN.
  - TFL=0 only in IDLE.

Optional Feature:
DBS_TIMEOUT_EN
- Defined: in RAISE or LOWER, when timer==MOVE_TIMEOUT-1 and the limit switch is still 0, go to FAULT on that edge (motor drives for exactly MOVE_TIMEOUT cycles).
- Undefined: no motion timeout; RAISE/LOWER wait indefinitely for the limit switch. MOVE_TIMEOUT is ignored.
- The contradictory-limit-switch fault exists in both builds.

Test Plan:
- Reset high 2 cycles, then idle inputs (BridgeDown=1) -> State=0; MT_UP, MT_DN, AL, TFL, BoatGo, Fault all 0.
- Full cycle with defaults: BoatReq=1, RoadClear=1; BridgeUp rises 5 cycles into RAISE; BoatReq drops 2 cycles into OPEN; BridgeDown rises 6 cycles into LOWER ->
  - State 1 for exactly 8 cycles, then 2 for 1 cycle, then 3 with MT_UP=1.
  - Then 4 with BoatGo=1 for 4 cycles, then 5 with MT_DN=1.
  - Then 0 with TFL=0.
- RoadClear held 0 for 20 cycles after WARN -> State=2 throughout; AL=1, TFL=1, MT_UP=0.
- DBS_TIMEOUT_EN defined, BridgeUp never asserts -> MT_UP=1 for 32 cycles, then State=6, Fault=1, MT_UP=0; stays 6 until Reset. Macro undefined, same stimulus -> State=3 after 100 cycles.
- BoatReq reasserted 3 cycles into LOWER -> next edge State=3, MT_DN=0, MT_UP=1; BridgeUp=1 -> OPEN again.
- BridgeUp=BridgeDown=1 while IDLE -> next edge State=6, Fault=1, TFL=1; Reset -> State=0, Fault=0.
